// File: rtl/axi_read_responder.sv
// AXI4 read-only subordinate over a word-addressed on-chip memory with
// programmable first-beat latency and FIXED/INCR/WRAP burst sequencing.
module axi_read_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h0F00_0000,
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] i_ld_idx,
    input  logic [31:0]                  i_ld_data,
    input  logic [31:0]                  i_axi_araddr,
    input  logic                         i_axi_arvalid,
    output logic                         o_axi_arready,
    input  logic [3:0]                   i_axi_arid,
    input  logic [7:0]                   i_axi_arlen,
    input  logic [2:0]                   i_axi_arsize,
    input  logic [1:0]                   i_axi_arburst,
    output logic [31:0]                  o_axi_rdata,
    output logic                         o_axi_rvalid,
    input  logic                         i_axi_rready,
    output logic [1:0]                   o_axi_rresp,
    output logic [3:0]                   o_axi_rid,
    output logic                         o_axi_rlast
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam int          DLY_W     = $clog2(LATENCY + 1);
    localparam logic [31:0] MEM_BYTES = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    logic [31:0] mem [MEM_WORDS];

    state_t             state_q,   state_d;
    logic [DLY_W-1:0]   delay_q,   delay_d;
    logic [29:0]        w_q,       w_d;
    logic [7:0]         len_q,     len_d;
    logic [1:0]         burst_q,   burst_d;
    logic               slverr_q,  slverr_d;
    logic [8:0]         cnt_q,     cnt_d;
    logic               arready_q, arready_d;
    logic               rvalid_q,  rvalid_d;
    logic               rlast_q,   rlast_d;
    logic [1:0]         rresp_q,   rresp_d;
    logic [3:0]         rid_q,     rid_d;
    logic [31:0]        rdata_q,   rdata_d;

    logic               ar_hs;
    logic               ar_err;
    logic [29:0]        beat_w;
    logic               beat_err;
    logic [8:0]         beat_cnt;
    logic [7:0]         beat_len;
    logic [31:0]        beat_off;
    logic [1:0]         beat_resp;
    logic [31:0]        beat_data;
    logic               load_beat;
    logic               unused_bits;

    // Word address of the beat following w for the given burst type; WRAP keeps
    // the upper bits and increments only inside the (len+1)-word window.
    function automatic logic [29:0] next_w(input logic [29:0] w,
                                           input logic [1:0]  burst,
                                           input logic [7:0]  len);
        logic [29:0] mask;
        mask = {26'd0, len[3:0]};
        case (burst)
            2'b00:   next_w = w;
            2'b10:   next_w = (w & ~mask) | ((w + 30'd1) & mask);
            default: next_w = w + 30'd1;
        endcase
    endfunction

    assign ar_hs  = i_axi_arvalid && arready_q;
    assign ar_err = (i_axi_arsize != 3'b010) || (i_axi_arburst == 2'b11) ||
                    ((i_axi_arburst == 2'b10) &&
                     !((i_axi_arlen == 8'd1) || (i_axi_arlen == 8'd3) ||
                       (i_axi_arlen == 8'd7) || (i_axi_arlen == 8'd15)));

    // Select the address/count of the beat that would be launched this cycle.
    always_comb begin
        beat_w   = w_q;
        beat_err = slverr_q;
        beat_cnt = 9'd0;
        beat_len = len_q;
        if (state_q == S_IDLE) begin
            beat_w   = i_axi_araddr[31:2];
            beat_err = ar_err;
            beat_len = i_axi_arlen;
        end else if (state_q == S_BURST) begin
            beat_w   = next_w(w_q, burst_q, len_q);
            beat_cnt = cnt_q + 9'd1;
        end else begin
            beat_w   = w_q;
        end
    end

    // Response and data for the selected beat; range check is per beat.
    always_comb begin
        beat_off = {beat_w, 2'b00} - BASE_ADDR;
        if (beat_err) begin
            beat_resp = 2'b10;
            beat_data = 32'd0;
        end else if (beat_off >= MEM_BYTES) begin
            beat_resp = 2'b11;
            beat_data = 32'd0;
        end else begin
            beat_resp = 2'b00;
            beat_data = mem[beat_off[IDX_W+1:2]];
        end
    end

    assign unused_bits = ^{i_axi_araddr[1:0], beat_off};

    // Next-state logic for the responder FSM and its registered outputs.
    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        w_d       = w_q;
        len_d     = len_q;
        burst_d   = burst_q;
        slverr_d  = slverr_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        load_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    w_d       = i_axi_araddr[31:2];
                    len_d     = i_axi_arlen;
                    burst_d   = i_axi_arburst;
                    slverr_d  = ar_err;
                    rid_d     = i_axi_arid;
                    cnt_d     = 9'd0;
                    arready_d = 1'b0;
                    if (LATENCY == 1) begin
                        load_beat = 1'b1;
                        state_d   = S_BURST;
                    end else begin
                        delay_d = DLY_W'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (delay_q == DLY_W'(1)) begin
                    load_beat = 1'b1;
                    state_d   = S_BURST;
                end else begin
                    delay_d = delay_q - DLY_W'(1);
                end
            end
            S_BURST: begin
                if (rvalid_q && i_axi_rready) begin
                    if (rlast_q) begin
                        state_d   = S_IDLE;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                    end
                end else begin
                    state_d = S_BURST;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
            end
        endcase
        if (load_beat) begin
            w_d      = beat_w;
            cnt_d    = beat_cnt;
            rvalid_d = 1'b1;
            rlast_d  = (beat_cnt == {1'b0, beat_len});
            rresp_d  = beat_resp;
            rdata_d  = beat_data;
        end else begin
            rvalid_d = rvalid_d;
        end
    end

    // State and output registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            delay_q   <= '0;
            w_q       <= 30'd0;
            len_q     <= 8'd0;
            burst_q   <= 2'd0;
            slverr_q  <= 1'b0;
            cnt_q     <= 9'd0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'd0;
            rid_q     <= 4'd0;
            rdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            w_q       <= w_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            slverr_q  <= slverr_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Backdoor preload port; memory contents deliberately survive reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset && i_ld_en) begin
            mem[i_ld_idx] <= i_ld_data;
        end
    end

    assign o_axi_arready = arready_q;
    assign o_axi_rvalid  = rvalid_q;
    assign o_axi_rlast   = rlast_q;
    assign o_axi_rresp   = rresp_q;
    assign o_axi_rid     = rid_q;
    assign o_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed, table-driven bench for axi_read_responder: latency, burst ordering,
// backpressure hold, range/size errors and mid-burst reset.
module tb_axi_read_responder;

    localparam logic [31:0] BASE    = 32'h0F00_0000;
    localparam int          WORDS   = 1024;
    localparam int          LAT     = 2;
    localparam logic [31:0] MA      = 32'h0000_0013;
    localparam logic [31:0] MB      = 32'h0010_0093;
    localparam logic [31:0] MC      = 32'hCCCC_0002;
    localparam logic [31:0] MD      = 32'hDDDD_0003;
    localparam logic [31:0] MLAST   = 32'hFFFF_03FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [3:0]       stall;
        logic [3:0][31:0] d;
        logic [3:0][1:0]  r;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    axi_read_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .LATENCY(LAT)) dut (
        .i_clock(clk), .i_reset(rst), .i_ld_en(ld_en), .i_ld_idx(ld_idx), .i_ld_data(ld_data),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
        .i_axi_arid(arid), .i_axi_arlen(arlen), .i_axi_arsize(arsize), .i_axi_arburst(arburst),
        .o_axi_rdata(rdata), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
        .o_axi_rresp(rresp), .o_axi_rid(rid), .o_axi_rlast(rlast)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] a, logic [7:0] l, logic [2:0] s, logic [1:0] b,
                                logic [3:0] id, logic [3:0] st,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3,
                                logic [1:0] r0, logic [1:0] r1, logic [1:0] r2, logic [1:0] r3);
        vec_t v;
        v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id; v.stall = st;
        v.d = {d3, d2, d1, d0};
        v.r = {r3, r2, r1, r0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        ld_en = 1'b1; ld_idx = idx; ld_data = data;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Issue one AR and consume/verify every beat; called and returns at a negedge.
    task automatic run_vec(input int k);
        vec_t v;
        int   lat;
        v = vecs[k];
        chk($sformatf("v%0d arready_idle", k), 32'(arready), 32'd1);
        araddr = v.addr; arlen = v.len; arsize = v.size; arburst = v.burst; arid = v.id;
        arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk($sformatf("v%0d arready_busy", k), 32'(arready), 32'd0);
        lat = 1;
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d latency", k), 32'(lat), 32'(LAT));
        if (!rvalid) return;
        for (int b = 0; b <= int'(v.len); b++) begin
            if (b == int'(v.stall)) begin
                rready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk($sformatf("v%0d hold_valid", k), 32'(rvalid), 32'd1);
                    chk($sformatf("v%0d hold_data", k), rdata, v.d[b]);
                    chk($sformatf("v%0d hold_last", k), 32'(rlast), 32'(b == int'(v.len)));
                end
                rready = 1'b1;
            end
            chk($sformatf("v%0d b%0d valid", k, b), 32'(rvalid), 32'd1);
            chk($sformatf("v%0d b%0d data", k, b), rdata, v.d[b]);
            chk($sformatf("v%0d b%0d resp", k, b), 32'(rresp), 32'(v.r[b]));
            chk($sformatf("v%0d b%0d id", k, b), 32'(rid), 32'(v.id));
            chk($sformatf("v%0d b%0d last", k, b), 32'(rlast), 32'(b == int'(v.len)));
            @(negedge clk);
        end
        chk($sformatf("v%0d rvalid_after", k), 32'(rvalid), 32'd0);
        chk($sformatf("v%0d arready_after", k), 32'(arready), 32'd1);
    endtask

    initial begin
        vecs[0]  = mk(BASE,         8'd1, 3'd2, 2'd1, 4'd3, 4'hF, MA, MB, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(BASE + 32'd4, 8'd0, 3'd2, 2'd0, 4'd5, 4'hF, MB, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(BASE,         8'd3, 3'd2, 2'd1, 4'd7, 4'd1, MA, MB, MC, MD, 0, 0, 0, 0);
        vecs[3]  = mk(BASE + 32'd8, 8'd3, 3'd2, 2'd2, 4'd1, 4'hF, MC, MD, MA, MB, 0, 0, 0, 0);
        vecs[4]  = mk(BASE + 32'hFFC, 8'd1, 3'd2, 2'd1, 4'd2, 4'hF, MLAST, 0, 0, 0, 0, 3, 0, 0);
        vecs[5]  = mk(BASE,         8'd1, 3'd3, 2'd1, 4'd4, 4'hF, 0, 0, 0, 0, 2, 2, 0, 0);
        vecs[6]  = mk(BASE,         8'd0, 3'd2, 2'd3, 4'd6, 4'hF, 0, 0, 0, 0, 2, 0, 0, 0);
        vecs[7]  = mk(BASE,         8'd2, 3'd2, 2'd2, 4'd8, 4'hF, 0, 0, 0, 0, 2, 2, 2, 0);
        vecs[8]  = mk(BASE + 32'd2, 8'd1, 3'd2, 2'd1, 4'd9, 4'hF, MA, MB, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(BASE + 32'hC, 8'd2, 3'd2, 2'd0, 4'hA, 4'hF, MD, MD, MD, 0, 0, 0, 0, 0);
        vecs[10] = mk(BASE - 32'd4, 8'd1, 3'd2, 2'd1, 4'hB, 4'hF, 0, MA, 0, 0, 3, 0, 0, 0);
        vecs[11] = mk(BASE + 32'hC, 8'd1, 3'd2, 2'd2, 4'hC, 4'hF, MD, MC, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; ld_en = 1'b0; ld_idx = 10'd0; ld_data = 32'd0;
        araddr = 32'd0; arvalid = 1'b0; arid = 4'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'd1;
        rready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset arready", 32'(arready), 32'd1);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset rlast", 32'(rlast), 32'd0);
        chk("reset rresp", 32'(rresp), 32'd0);
        chk("reset rid", 32'(rid), 32'd0);
        chk("reset rdata", rdata, 32'd0);

        preload(10'd0, MA);
        preload(10'd1, MB);
        preload(10'd2, MC);
        preload(10'd3, MD);
        preload(10'd1023, MLAST);

        for (int k = 0; k < NV; k++) run_vec(k);

        // Reset during the second beat of a len=3 burst; a preload attempted
        // during reset must be ignored.
        araddr = BASE; arlen = 8'd3; arsize = 3'd2; arburst = 2'd1; arid = 4'd5;
        arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        begin
            int t;
            t = 0;
            while (!rvalid && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        chk("rst_mid beat0 data", rdata, MA);
        @(negedge clk);
        chk("rst_mid beat1 data", rdata, MB);
        rst = 1'b1; ld_en = 1'b1; ld_idx = 10'd0; ld_data = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0; ld_en = 1'b0;
        chk("rst_mid rvalid", 32'(rvalid), 32'd0);
        chk("rst_mid arready", 32'(arready), 32'd1);
        chk("rst_mid rlast", 32'(rlast), 32'd0);
        chk("rst_mid rdata", rdata, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_mid no_late_valid", 32'(rvalid), 32'd0);
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
